// File: rtl/perf_counter_arbiter_if.sv
// Purpose : CPU/debug requester, snapshot and counter-bank signals of perf_counter_arbiter.
// Latency : n/a (signal bundle only).
// Backpressure: requests are held by the requester until its one-cycle resp pulse.
interface perf_counter_arbiter_if;
    logic        cpu_read;
    logic        cpu_clear;
    logic [4:0]  cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_resp;

    logic        dbg_read;
    logic        dbg_clear;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_rdata;
    logic        dbg_resp;

    logic        snap;
    logic        snap_busy;

    logic [4:0]  pc_read_src;
    logic        pc_clear;
    logic [31:0] pc_read_data;

    // Arbiter side
    modport slave (
        input  cpu_read, cpu_clear, cpu_addr,
        output cpu_rdata, cpu_resp,
        input  dbg_read, dbg_clear, dbg_addr,
        output dbg_rdata, dbg_resp,
        input  snap,
        output snap_busy,
        output pc_read_src, pc_clear,
        input  pc_read_data
    );

    // Requester / counter-bank side
    modport master (
        output cpu_read, cpu_clear, cpu_addr,
        input  cpu_rdata, cpu_resp,
        output dbg_read, dbg_clear, dbg_addr,
        input  dbg_rdata, dbg_resp,
        output snap,
        input  snap_busy,
        input  pc_read_src, pc_clear,
        output pc_read_data
    );
endinterface

// File: rtl/perf_counter_arbiter.sv
// Purpose : round-robin CPU/debug access to a perf counter bank, optional snapshot shadow (PERF_SNAPSHOT_EN).
// Latency : request sampled in IDLE -> resp two cycles later; one IDLE cycle between transactions.
// Backpressure: requesters hold their request until resp; they also wait while a snapshot scan runs.
module perf_counter_arbiter #(
    parameter int NUM_COUNTERS = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    perf_counter_arbiter_if.slave bus
);

`ifdef PERF_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    localparam logic [4:0] NC = 5'(NUM_COUNTERS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, SCAN} state_t;

    state_t      r_state;
    logic        r_owner;        // 1 = debug requester owns the current transaction
    logic [4:0]  r_addr;
    logic        r_rr;           // 1 = debug preferred on the next tie
    logic [4:0]  r_scan_idx;
    logic [4:0]  r_pc_read_src;
    logic        r_pc_clear;     // latched clear op, already qualified by address range
    logic [31:0] r_data;
    logic        r_cpu_resp;
    logic        r_dbg_resp;

    logic        w_cpu_req;
    logic        w_dbg_req;
    logic        w_pick_dbg;
    logic [4:0]  w_pick_addr;
    logic        w_pick_clr;
    logic        w_acc_shadow;
    logic [31:0] w_shadow_dat;
    logic        w_snap_pending;

    // Addresses 16+i map onto the shadow copy of counter i when the snapshot feature is built.
    function automatic logic in_shadow(input logic [4:0] a);
        return SNAP_EN && a[4] && ({1'b0, a[3:0]} < NC);
    endfunction

    assign w_cpu_req    = bus.cpu_read | bus.cpu_clear;
    assign w_dbg_req    = bus.dbg_read | bus.dbg_clear;
    assign w_pick_dbg   = w_dbg_req & (~w_cpu_req | r_rr);
    assign w_pick_addr  = w_pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign w_pick_clr   = w_pick_dbg ? bus.dbg_clear : bus.cpu_clear;
    assign w_acc_shadow = in_shadow(r_addr);

`ifdef PERF_SNAPSHOT_EN
    logic        r_snap_pend;
    logic [31:0] r_shadow [16];

    // Pending snapshot flag: set by a snap pulse, consumed when IDLE launches the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_pend <= 1'b0;
        end else if (r_state == IDLE && r_snap_pend) begin
            r_snap_pend <= 1'b0;
        end else if (bus.snap && r_state != SCAN) begin
            r_snap_pend <= 1'b1;
        end
    end

    // Shadow capture: scan cycle i copies the live value of counter i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_shadow[i] <= '0;
        end else if (r_state == SCAN) begin
            r_shadow[r_scan_idx[3:0]] <= bus.pc_read_data;
        end
    end

    assign w_snap_pending = r_snap_pend;
    assign w_shadow_dat   = r_shadow[r_addr[3:0]];
    assign bus.snap_busy  = r_snap_pend | (r_state == SCAN);
`else
    logic w_unused_snap;
    assign w_unused_snap  = bus.snap;
    assign w_snap_pending = 1'b0;
    assign w_shadow_dat   = '0;
    assign bus.snap_busy  = 1'b0;
`endif

    // Main FSM: arbitration, counter access, response pulse and snapshot scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_addr        <= '0;
            r_rr          <= 1'b0;
            r_scan_idx    <= '0;
            r_pc_read_src <= '0;
            r_pc_clear    <= 1'b0;
            r_data        <= '0;
            r_cpu_resp    <= 1'b0;
            r_dbg_resp    <= 1'b0;
        end else begin
            r_pc_read_src <= '0;
            r_pc_clear    <= 1'b0;
            r_cpu_resp    <= 1'b0;
            r_dbg_resp    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_snap_pending) begin
                        r_state    <= SCAN;
                        r_scan_idx <= '0;
                    end else if (w_cpu_req || w_dbg_req) begin
                        r_state       <= ACCESS;
                        r_owner       <= w_pick_dbg;
                        r_addr        <= w_pick_addr;
                        r_pc_read_src <= in_shadow(w_pick_addr) ? 5'd0 : w_pick_addr;
                        r_pc_clear    <= w_pick_clr && (w_pick_addr < NC);
                    end
                end
                ACCESS: begin
                    if (w_acc_shadow)
                        r_data <= w_shadow_dat;
                    else if (r_addr < NC)
                        r_data <= bus.pc_read_data;
                    else
                        r_data <= '0;
                    r_cpu_resp <= ~r_owner;
                    r_dbg_resp <= r_owner;
                    r_state    <= RESP;
                end
                RESP: begin
                    r_rr    <= ~r_owner;
                    r_state <= IDLE;
                end
                SCAN: begin
                    if (r_scan_idx == NC - 5'd1) begin
                        r_state <= IDLE;
                    end else begin
                        r_scan_idx    <= r_scan_idx + 5'd1;
                        r_pc_read_src <= r_scan_idx + 5'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.pc_read_src = r_pc_read_src;
    assign bus.pc_clear    = r_pc_clear;
    assign bus.cpu_resp    = r_cpu_resp;
    assign bus.dbg_resp    = r_dbg_resp;
    assign bus.cpu_rdata   = r_cpu_resp ? r_data : '0;
    assign bus.dbg_rdata   = r_dbg_resp ? r_data : '0;

endmodule

// File: doc/perf_counter_arbiter.md
PERF_COUNTER_ARBITER -- requirements
Module: perf_counter_arbiter

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 9, meaning the number of implemented counter indices (0..NUM_COUNTERS-1), legal range 1..16.
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port cpu_read  input  1  CPU read request, held until cpu_resp.
REQ-005 SHALL have port cpu_clear  input  1  CPU read-and-clear request, held until cpu_resp.
REQ-006 SHALL have port cpu_addr  input  5  CPU counter index.
REQ-007 SHALL have port cpu_rdata  output  32  CPU return data, valid while cpu_resp is high.
REQ-008 SHALL have port cpu_resp  output  1  one-cycle CPU completion pulse.
REQ-009 SHALL have ports dbg_read, dbg_clear, dbg_addr, dbg_rdata, dbg_resp, with the same directions, widths and meanings as the cpu_* ports, serving the debug requester.
REQ-010 SHALL have port snap  input  1  snapshot trigger pulse.
REQ-011 SHALL have port snap_busy  output  1  high while a snapshot is pending or scanning.
REQ-012 SHALL have port pc_read_src  output  5  counter select driven to the counter bank.
REQ-013 SHALL have port pc_clear  output  1  clear strobe to the counter bank.
REQ-014 SHALL have port pc_read_data  input  32  combinational counter value for pc_read_src.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP, and SCAN.
REQ-016 In IDLE, a pending snapshot SHALL win first (enter SCAN); otherwise, if both requesters are active, the one not granted last SHALL win; a single active requester SHALL win outright.
REQ-017 On a requester grant, the block SHALL latch the requester id, the address, and the op (clear if that requester's clear is high, else read), then go to ACCESS.
REQ-018 In ACCESS, pc_read_src SHALL equal the latched address, pc_read_data SHALL be captured, and pc_clear SHALL be high for exactly this one cycle when the op is clear and address < NUM_COUNTERS; the FSM SHALL then go to RESP.
REQ-019 In RESP, the winner's resp SHALL be high for one cycle with rdata equal to the captured (pre-clear) value; the round-robin pointer SHALL update to the winner; the FSM SHALL then return to IDLE.
REQ-020 Latency SHALL be: request seen in IDLE at cycle N gives resp at cycle N+2; one IDLE cycle SHALL always separate transactions.
REQ-021 An address >= NUM_COUNTERS SHALL return rdata 0 with no pc_clear pulse.
REQ-022 Outside ACCESS and SCAN, pc_read_src SHALL be 0 and pc_clear 0; a non-granted resp/rdata SHALL be 0.
REQ-023 A snap pulse SHALL set a pending flag; snap while pending or scanning SHALL be ignored.
REQ-024 SCAN SHALL last NUM_COUNTERS cycles, driving pc_read_src = i in scan cycle i, never asserting pc_clear, and then return to IDLE; requesters SHALL wait during SCAN.

Reset
REQ-025 rst SHALL force IDLE immediately, including mid-transaction or mid-scan, and SHALL clear the pending snapshot, the round-robin pointer (CPU preferred next), all outputs, and any shadow storage; an interrupted transaction SHALL produce no resp.

Configuration
REQ-026 With PERF_SNAPSHOT_EN defined, SCAN SHALL store pc_read_data into shadow[i], and read/clear addresses 16+i (i < NUM_COUNTERS) SHALL return shadow[i] without using the counter bank (ACCESS drives pc_read_src 0, no pc_clear); clear SHALL leave the shadow unchanged.
REQ-027 Without PERF_SNAPSHOT_EN, no shadow storage SHALL exist, snap SHALL be ignored, snap_busy SHALL be tied 0, SCAN SHALL be unreachable, and addresses >= NUM_COUNTERS SHALL follow REQ-021.

Verification
REQ-028 Bench: cpu_read addr 3 with pc_read_data 0x2A held -> cpu_resp exactly 2 cycles after the IDLE sample, cpu_rdata 0x2A, pc_clear never high.
REQ-029 Bench: cpu and dbg reads asserted in the same cycle after reset -> CPU served first; dbg served next after one IDLE gap; repeat -> grants alternate.
REQ-030 Bench: dbg_clear addr 7 with counter value 5 -> one pc_clear pulse with pc_read_src 7, dbg_rdata 5.
REQ-031 Bench: cpu_read addr 20 without the macro -> cpu_rdata 0, no pc_clear; with the macro, after snap and counters 0..8 = 10..18 -> addr 20 returns 14 and snap_busy spans the scan.
REQ-032 Bench: rst asserted during ACCESS and separately during SCAN cycle 4 -> immediate IDLE, all outputs 0, no resp, shadow zeroed.
